// File: rtl/shift_register.sv
// Persistence filter: `on` asserts once `in` has been sampled high on N consecutive clock edges.
// Optional build macro SHIFT_REGISTER_FILL_COUNT_EN adds a saturating fill_count output.
module shift_register #(
    parameter int N = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in,
    output logic                       on
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
    ,
    output logic [$clog2(N+1)-1:0]     fill_count
`endif
);

    logic [N-1:0] sr;

    // A loop rather than a slice-concatenation keeps N == 1 legal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr[0] <= in;
            for (int k = 1; k < N; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign on = &sr;

`ifdef SHIFT_REGISTER_FILL_COUNT_EN
    localparam int CW = $clog2(N+1);
    localparam logic [CW-1:0] FULL = CW'(N);

    // Tracks the same run length the shift register holds, so it reaches FULL exactly when on is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_count <= '0;
        end else if (!in) begin
            fill_count <= '0;
        end else if (fill_count != FULL) begin
            fill_count <= fill_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register at N = 128, N = 1 and N = 256, with immediate-assertion checks.
module tb_shift_register;

    logic clk = 1'b0;
    logic reset;
    logic in_a, in_b, in_c;
    logic on_a, on_b, on_c;
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
    logic [7:0] fc_a;
    logic [0:0] fc_b;
    logic [8:0] fc_c;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] pat = 16'hA5C3;

    always #5 clk = ~clk;

    shift_register #(.N(128)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .on(on_a)
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
        , .fill_count(fc_a)
`endif
    );

    shift_register #(.N(1)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .on(on_b)
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
        , .fill_count(fc_b)
`endif
    );

    shift_register #(.N(256)) dut_c (
        .clk(clk), .reset(reset), .in(in_c), .on(on_c)
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
        , .fill_count(fc_c)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic exp_on, input int exp_fc);
        checkOutput(tag, {31'b0, on_a}, {31'b0, exp_on});
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
        checkOutput({tag, "_fc"}, {24'b0, fc_a}, exp_fc);
`endif
    endtask

    initial begin
        reset = 1'b0;
        in_a = 1'b1;
        in_b = 1'b1;
        in_c = 1'b1;

        // Reset held with input high: nothing may qualify.
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkA("reset_on_a", 1'b0, 0);
            checkOutput("reset_on_b", {31'b0, on_b}, 32'd0);
            checkOutput("reset_on_c", {31'b0, on_c}, 32'd0);
        end

        // Release; edge 1 is the next rising edge. A and C held high, B walks a pattern.
        reset = 1'b1;
        for (int e = 1; e <= 628; e++) begin
            in_b = pat[e % 16];
            applyStimulus();
            checkA("qual_a", (e >= 128) ? 1'b1 : 1'b0, (e >= 128) ? 128 : e);
            checkOutput("qual_c", {31'b0, on_c}, (e >= 256) ? 32'd1 : 32'd0);
            checkOutput("n1_b", {31'b0, on_b}, {31'b0, pat[e % 16]});
`ifdef SHIFT_REGISTER_FILL_COUNT_EN
            checkOutput("qual_c_fc", {23'b0, fc_c}, (e >= 256) ? 32'd256 : e);
            checkOutput("n1_b_fc", {31'b0, fc_b}, {31'b0, pat[e % 16]});
`endif
        end

        // Single-edge drop-out releases at once and restarts the full count.
        in_a = 1'b0;
        applyStimulus();
        checkA("drop_a", 1'b0, 0);
        in_a = 1'b1;
        for (int e = 1; e <= 128; e++) begin
            applyStimulus();
            checkA("requal_a", (e == 128) ? 1'b1 : 1'b0, e);
        end

        // Glitch case from a clean reset: 100 high, 1 low, then high -> first rise after edge 229.
        reset = 1'b0;
        #1;
        checkA("glitch_reset_a", 1'b0, 0);
        reset = 1'b1;
        for (int e = 1; e <= 229; e++) begin
            in_a = (e == 101) ? 1'b0 : 1'b1;
            applyStimulus();
            checkA("glitch_a", (e == 229) ? 1'b1 : 1'b0, (e <= 100) ? e : ((e == 101) ? 0 : e - 101));
        end

        // Async reset pulse between edges must clear on with no clock edge.
        in_a = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkA("async_a", 1'b0, 0);
        checkOutput("async_c", {31'b0, on_c}, 32'd0);
        reset = 1'b1;
        for (int e = 1; e <= 128; e++) begin
            applyStimulus();
            checkA("post_async_a", (e == 128) ? 1'b1 : 1'b0, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
